// File: rtl/box_result_scheduler_if.sv
// Result bus between box_result_scheduler (master) and the shared box consumer (slave).
interface box_result_scheduler_if;
  logic        out_valid;
  logic        out_ready;
  logic        out_ch;
  logic [10:0] out_up;
  logic [10:0] out_down;
  logic [10:0] out_left;
  logic [10:0] out_right;
  logic        out_flag;
  logic        out_held;

  modport master (
    output out_valid, out_ch, out_up, out_down, out_left, out_right, out_flag, out_held,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_ch, out_up, out_down, out_left, out_right, out_flag, out_held,
    output out_ready
  );
endinterface

// File: rtl/box_result_scheduler.sv
// Latches two detector channels' boxes at their frame boundaries and issues them
// round-robin to one consumer. Optional last-good-box hold: define BOX_HOLD_EN.
module box_result_scheduler #(
  parameter logic [10:0] IMG_HDISP = 11'd1024,
  parameter logic [10:0] IMG_VDISP = 11'd768
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ch0_vsync,
  input  logic [10:0] ch0_up,
  input  logic [10:0] ch0_down,
  input  logic [10:0] ch0_left,
  input  logic [10:0] ch0_right,
  input  logic        ch0_flag,
  input  logic        ch1_vsync,
  input  logic [10:0] ch1_up,
  input  logic [10:0] ch1_down,
  input  logic [10:0] ch1_left,
  input  logic [10:0] ch1_right,
  input  logic        ch1_flag,
  box_result_scheduler_if.master res,
  output logic [7:0]  drop_cnt0,
  output logic [7:0]  drop_cnt1
);
`ifdef BOX_HOLD_EN
  localparam logic [3:0] HOLD_FRAMES = 4'd4;
`endif

  typedef enum logic {ST_IDLE = 1'b0, ST_PRESENT = 1'b1} state_t;

  function automatic logic box_in_range(input logic [10:0] up, input logic [10:0] down,
                                        input logic [10:0] left, input logic [10:0] right);
    return (left <= right) && (up <= down) && (right < IMG_HDISP) && (down < IMG_VDISP);
  endfunction

  // Boxes are packed as {up, down, left, right}.
  logic [1:0]  vsync_s, cap_s, clr_s, ok_s, in_flag_s;
  logic [1:0]  cap_flag_s, cap_held_s;
  logic [43:0] in_box_s  [2];
  logic [43:0] cap_box_s [2];
  logic        grant_s, load_s;

  logic [1:0]  vs_d_r, pend_r, slot_flag_r, slot_held_r;
  logic        armed_r, last_r;
  logic [43:0] slot_box_r [2];
  logic [7:0]  drop_r [2];
  state_t      state_r;
  logic        out_ch_r, out_flag_r, out_held_r;
  logic [43:0] out_box_r;

`ifdef BOX_HOLD_EN
  logic [43:0] good_box_r  [2];
  logic [3:0]  miss_r      [2];
  logic [1:0]  good_seen_r;
`endif

  assign vsync_s     = {ch1_vsync, ch0_vsync};
  assign in_flag_s   = {ch1_flag, ch0_flag};
  assign in_box_s[0] = {ch0_up, ch0_down, ch0_left, ch0_right};
  assign in_box_s[1] = {ch1_up, ch1_down, ch1_left, ch1_right};

  // armed_r masks the first sample after reset so a vsync already high is not an edge.
  assign cap_s   = vsync_s & ~vs_d_r & {2{armed_r}};
  assign load_s  = ((state_r == ST_IDLE) | res.out_ready) & (|pend_r);
  assign grant_s = (&pend_r) ? ~last_r : pend_r[1];
  assign clr_s   = load_s ? (grant_s ? 2'b10 : 2'b01) : 2'b00;

  // Validate the incoming box and choose what the slot stores on capture.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      ok_s[n]       = in_flag_s[n] & box_in_range(in_box_s[n][43:33], in_box_s[n][32:22],
                                                  in_box_s[n][21:11], in_box_s[n][10:0]);
      cap_flag_s[n] = ok_s[n];
      cap_box_s[n]  = ok_s[n] ? in_box_s[n] : 44'd0;
      cap_held_s[n] = 1'b0;
`ifdef BOX_HOLD_EN
      if (!ok_s[n] && good_seen_r[n] && (miss_r[n] < HOLD_FRAMES)) begin
        cap_flag_s[n] = 1'b1;
        cap_box_s[n]  = good_box_r[n];
        cap_held_s[n] = 1'b1;
      end else begin
        cap_held_s[n] = 1'b0;
      end
`endif
    end
  end

`ifdef BOX_HOLD_EN
  // Track the last good box per channel and how many frames it has been re-issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      good_seen_r <= 2'b00;
      for (int n = 0; n < 2; n++) begin
        good_box_r[n] <= 44'd0;
        miss_r[n]     <= 4'd0;
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (cap_s[n] && ok_s[n]) begin
          good_box_r[n]  <= in_box_s[n];
          good_seen_r[n] <= 1'b1;
          miss_r[n]      <= 4'd0;
        end else if (cap_s[n] && cap_held_s[n]) begin
          miss_r[n] <= miss_r[n] + 4'd1;
        end else begin
          miss_r[n] <= miss_r[n];
        end
      end
    end
  end
`endif

  // Edge detect, pending slots and saturating overwrite counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_d_r      <= 2'b00;
      armed_r     <= 1'b0;
      pend_r      <= 2'b00;
      slot_flag_r <= 2'b00;
      slot_held_r <= 2'b00;
      for (int n = 0; n < 2; n++) begin
        slot_box_r[n] <= 44'd0;
        drop_r[n]     <= 8'd0;
      end
    end else begin
      vs_d_r  <= vsync_s;
      armed_r <= 1'b1;
      pend_r  <= cap_s | (pend_r & ~clr_s);
      for (int n = 0; n < 2; n++) begin
        if (cap_s[n]) begin
          slot_box_r[n]  <= cap_box_s[n];
          slot_flag_r[n] <= cap_flag_s[n];
          slot_held_r[n] <= cap_held_s[n];
        end
        // A capture into a slot being issued this cycle is not an overwrite.
        if (cap_s[n] && pend_r[n] && !clr_s[n] && (drop_r[n] != 8'd255)) begin
          drop_r[n] <= drop_r[n] + 8'd1;
        end
      end
    end
  end

  // Output stage: load the granted slot whenever the output is free or being accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      last_r     <= 1'b1;
      out_ch_r   <= 1'b0;
      out_box_r  <= 44'd0;
      out_flag_r <= 1'b0;
      out_held_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (load_s) begin
            out_ch_r   <= grant_s;
            out_box_r  <= slot_box_r[grant_s];
            out_flag_r <= slot_flag_r[grant_s];
            out_held_r <= slot_held_r[grant_s];
            last_r     <= grant_s;
            state_r    <= ST_PRESENT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_PRESENT: begin
          if (load_s) begin
            out_ch_r   <= grant_s;
            out_box_r  <= slot_box_r[grant_s];
            out_flag_r <= slot_flag_r[grant_s];
            out_held_r <= slot_held_r[grant_s];
            last_r     <= grant_s;
            state_r    <= ST_PRESENT;
          end else if (res.out_ready) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_PRESENT;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign res.out_valid = (state_r == ST_PRESENT);
  assign res.out_ch    = out_ch_r;
  assign res.out_up    = out_box_r[43:33];
  assign res.out_down  = out_box_r[32:22];
  assign res.out_left  = out_box_r[21:11];
  assign res.out_right = out_box_r[10:0];
  assign res.out_flag  = out_flag_r;
  assign res.out_held  = out_held_r;
  assign drop_cnt0     = drop_r[0];
  assign drop_cnt1     = drop_r[1];
endmodule

// File: tb/tb_box_result_scheduler.sv
// Directed testbench for box_result_scheduler; outputs are sampled on the falling edge.
module tb_box_result_scheduler;
  logic        clk = 1'b0;
  logic        rst;
  logic        ch0_vsync, ch1_vsync, ch0_flag, ch1_flag;
  logic [10:0] ch0_up, ch0_down, ch0_left, ch0_right;
  logic [10:0] ch1_up, ch1_down, ch1_left, ch1_right;
  logic [7:0]  drop_cnt0, drop_cnt1;
  logic [47:0] obs;
  int          n_cmp = 0;
  int          n_err = 0;

  box_result_scheduler_if bus ();

  box_result_scheduler dut (
    .clk(clk), .rst(rst),
    .ch0_vsync(ch0_vsync), .ch0_up(ch0_up), .ch0_down(ch0_down),
    .ch0_left(ch0_left), .ch0_right(ch0_right), .ch0_flag(ch0_flag),
    .ch1_vsync(ch1_vsync), .ch1_up(ch1_up), .ch1_down(ch1_down),
    .ch1_left(ch1_left), .ch1_right(ch1_right), .ch1_flag(ch1_flag),
    .res(bus), .drop_cnt0(drop_cnt0), .drop_cnt1(drop_cnt1)
  );

  always #5 clk = ~clk;

  // {valid, ch, up, down, left, right, flag, held}
  assign obs = {bus.out_valid, bus.out_ch, bus.out_up, bus.out_down,
                bus.out_left, bus.out_right, bus.out_flag, bus.out_held};

  task automatic set_box(input logic ch, input logic [10:0] u, input logic [10:0] d,
                         input logic [10:0] l, input logic [10:0] r, input logic f);
    if (!ch) begin
      ch0_up = u; ch0_down = d; ch0_left = l; ch0_right = r; ch0_flag = f;
    end else begin
      ch1_up = u; ch1_down = d; ch1_left = l; ch1_right = r; ch1_flag = f;
    end
  endtask

  task automatic pulse(input logic v0, input logic v1);
    @(negedge clk); ch0_vsync = v0; ch1_vsync = v1;
    @(negedge clk); ch0_vsync = 1'b0; ch1_vsync = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; ch0_vsync = 1'b1; ch1_vsync = 1'b0; bus.out_ready = 1'b0;
    set_box(1'b0, 11'd0, 11'd0, 11'd0, 11'd0, 1'b0);
    set_box(1'b1, 11'd0, 11'd0, 11'd0, 11'd0, 1'b0);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (obs !== 48'd0) begin
      n_err++; $display("FAIL reset_outputs: got %h want %h", obs, 48'd0);
    end
    n_cmp++;
    if ({drop_cnt0, drop_cnt1} !== 16'd0) begin
      n_err++; $display("FAIL reset_drops: got %h want 0000", {drop_cnt0, drop_cnt1});
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_vsync_high_gated: got valid %b want 0", bus.out_valid);
    end
    ch0_vsync = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    set_box(1'b0, 11'd10, 11'd50, 11'd20, 11'd80, 1'b1);
    pulse(1'b1, 1'b0);
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL basic_latency: got valid %b want 0", bus.out_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (obs !== {1'b1, 1'b0, 11'd10, 11'd50, 11'd20, 11'd80, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL basic_issue: got %h", obs);
    end
    set_box(1'b0, 11'd1, 11'd1, 11'd1, 11'd1, 1'b1);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (obs !== {1'b1, 1'b0, 11'd10, 11'd50, 11'd20, 11'd80, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL basic_stall_hold: got %h", obs);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs !== {1'b0, 1'b0, 11'd10, 11'd50, 11'd20, 11'd80, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL basic_accept_idle: got %h", obs);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_round_robin;
    do_reset();
    bus.out_ready = 1'b1;
    set_box(1'b0, 11'd1, 11'd2, 11'd3, 11'd4, 1'b1);
    set_box(1'b1, 11'd5, 11'd6, 11'd7, 11'd8, 1'b1);
    pulse(1'b1, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (obs !== {1'b1, 1'b0, 11'd1, 11'd2, 11'd3, 11'd4, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL rr_first_tie_ch0: got %h", obs);
    end
    @(negedge clk);
    n_cmp++;
    if (obs !== {1'b1, 1'b1, 11'd5, 11'd6, 11'd7, 11'd8, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL rr_then_ch1: got %h", obs);
    end
    @(negedge clk);
    n_cmp++;
    if (obs !== {1'b0, 1'b1, 11'd5, 11'd6, 11'd7, 11'd8, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL rr_drain_idle: got %h", obs);
    end
    set_box(1'b0, 11'd9, 11'd10, 11'd11, 11'd12, 1'b1);
    pulse(1'b1, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (obs !== {1'b1, 1'b0, 11'd9, 11'd10, 11'd11, 11'd12, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL rr_single_ch0: got %h", obs);
    end
    set_box(1'b0, 11'd13, 11'd14, 11'd15, 11'd16, 1'b1);
    set_box(1'b1, 11'd17, 11'd18, 11'd19, 11'd20, 1'b1);
    pulse(1'b1, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (obs !== {1'b1, 1'b1, 11'd17, 11'd18, 11'd19, 11'd20, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL rr_second_tie_ch1: got %h", obs);
    end
    @(negedge clk);
    n_cmp++;
    if (obs !== {1'b1, 1'b0, 11'd13, 11'd14, 11'd15, 11'd16, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL rr_second_tie_ch0: got %h", obs);
    end
  endtask

  task automatic test_validation;
    logic [10:0] tu [7];
    logic [10:0] td [7];
    logic [10:0] tl [7];
    logic [10:0] tr [7];
    logic [6:0]  tf;
    logic [6:0]  tok;
    logic [47:0] exp;
    tu = '{11'd1, 11'd1, 11'd1,   11'd3, 11'd0,   11'd4, 11'd7};
    td = '{11'd2, 11'd2, 11'd768, 11'd1, 11'd767, 11'd5, 11'd7};
    tl = '{11'd30, 11'd5, 11'd5,  11'd5, 11'd0,   11'd6, 11'd9};
    tr = '{11'd20, 11'd1024, 11'd6, 11'd6, 11'd1023, 11'd7, 11'd9};
    tf  = 7'b101_1111;
    tok = 7'b101_0000;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      set_box(1'b0, tu[i], td[i], tl[i], tr[i], tf[i]);
      pulse(1'b1, 1'b0);
      @(negedge clk);
      exp = tok[i] ? {1'b1, 1'b0, tu[i], td[i], tl[i], tr[i], 1'b1, 1'b0}
                   : {1'b1, 1'b0, 44'd0, 1'b0, 1'b0};
      n_cmp++;
      if (obs !== exp) begin
        n_err++; $display("FAIL validate_%0d: got %h want %h", i, obs, exp);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_drop;
    bus.out_ready = 1'b0;
    set_box(1'b0, 11'd21, 11'd22, 11'd23, 11'd24, 1'b1);
    pulse(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      set_box(1'b1, 11'd31 + 11'(i), 11'd32 + 11'(i), 11'd33 + 11'(i), 11'd34 + 11'(i), 1'b1);
      pulse(1'b0, 1'b1);
    end
    n_cmp++;
    if ({drop_cnt0, drop_cnt1} !== {8'd0, 8'd2}) begin
      n_err++; $display("FAIL drop_three_edges: got %0d/%0d want 0/2", drop_cnt0, drop_cnt1);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs !== {1'b1, 1'b1, 11'd33, 11'd34, 11'd35, 11'd36, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL drop_last_box_issued: got %h", obs);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL drop_no_extra_issue: got valid %b want 0", bus.out_valid);
    end
    bus.out_ready = 1'b0;
    do_reset();
    pulse(1'b1, 1'b0);
    repeat (255) pulse(1'b0, 1'b1);
    n_cmp++;
    if (drop_cnt1 !== 8'd254) begin
      n_err++; $display("FAIL drop_count_254: got %0d want 254", drop_cnt1);
    end
    repeat (6) pulse(1'b0, 1'b1);
    n_cmp++;
    if (drop_cnt1 !== 8'd255) begin
      n_err++; $display("FAIL drop_saturate: got %0d want 255", drop_cnt1);
    end
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    do_reset();
    bus.out_ready = 1'b0;
    set_box(1'b0, 11'd41, 11'd42, 11'd43, 11'd44, 1'b1);
    pulse(1'b1, 1'b0);
    set_box(1'b1, 11'd51, 11'd52, 11'd53, 11'd54, 1'b1);
    pulse(1'b0, 1'b1);
    @(negedge clk);
    set_box(1'b1, 11'd61, 11'd62, 11'd63, 11'd64, 1'b1);
    ch1_vsync = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    ch1_vsync = 1'b0;
    n_cmp++;
    if (obs !== {1'b1, 1'b1, 11'd51, 11'd52, 11'd53, 11'd54, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL b2b_old_content: got %h", obs);
    end
    n_cmp++;
    if (drop_cnt1 !== 8'd0) begin
      n_err++; $display("FAIL b2b_no_drop: got %0d want 0", drop_cnt1);
    end
    @(negedge clk);
    n_cmp++;
    if (obs !== {1'b1, 1'b1, 11'd61, 11'd62, 11'd63, 11'd64, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL b2b_new_content: got %h", obs);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL b2b_idle: got valid %b want 0", bus.out_valid);
    end
    bus.out_ready = 1'b0;
  endtask

`ifdef BOX_HOLD_EN
  task automatic test_hold;
    logic [47:0] exp;
    do_reset();
    bus.out_ready = 1'b1;
    set_box(1'b0, 11'd100, 11'd200, 11'd300, 11'd400, 1'b1);
    pulse(1'b1, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (obs !== {1'b1, 1'b0, 11'd100, 11'd200, 11'd300, 11'd400, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL hold_good: got %h", obs);
    end
    set_box(1'b0, 11'd7, 11'd8, 11'd9, 11'd10, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      pulse(1'b1, 1'b0);
      @(negedge clk);
      exp = (i <= 4) ? {1'b1, 1'b0, 11'd100, 11'd200, 11'd300, 11'd400, 1'b1, 1'b1}
                     : {1'b1, 1'b0, 44'd0, 1'b0, 1'b0};
      n_cmp++;
      if (obs !== exp) begin
        n_err++; $display("FAIL hold_frame_%0d: got %h want %h", i, obs, exp);
      end
    end
    bus.out_ready = 1'b0;
  endtask
`else
  task automatic test_no_hold;
    do_reset();
    bus.out_ready = 1'b1;
    set_box(1'b0, 11'd100, 11'd200, 11'd300, 11'd400, 1'b1);
    pulse(1'b1, 1'b0);
    set_box(1'b0, 11'd7, 11'd8, 11'd9, 11'd10, 1'b0);
    pulse(1'b1, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (obs !== {1'b1, 1'b0, 44'd0, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL nohold_passthrough: got %h", obs);
    end
    bus.out_ready = 1'b0;
  endtask
`endif

  task automatic test_reset_mid;
    bus.out_ready = 1'b0;
    set_box(1'b0, 11'd71, 11'd72, 11'd73, 11'd74, 1'b1);
    pulse(1'b1, 1'b0);
    set_box(1'b1, 11'd81, 11'd82, 11'd83, 11'd84, 1'b1);
    pulse(1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (obs !== 48'd0) begin
      n_err++; $display("FAIL rstmid_async_clear: got %h want 0", obs);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (obs !== 48'd0) begin
      n_err++; $display("FAIL rstmid_pending_discarded: got %h want 0", obs);
    end
    pulse(1'b0, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (obs !== {1'b1, 1'b1, 11'd81, 11'd82, 11'd83, 11'd84, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL rstmid_new_edge: got %h", obs);
    end
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_validation();
    test_drop();
    test_back_to_back();
`ifdef BOX_HOLD_EN
    test_hold();
`else
    test_no_hold();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/box_result_scheduler.md
# box_result_scheduler

Collects per-frame bounding-box results from two human-detector instances, one per camera in the stitching path. It shares a single downstream box consumer (overlay drawer / result reporter) between the two channels. Each channel's result is latched at that channel's frame boundary into a one-deep pending slot. Pending results are issued round-robin over a valid/ready handshake, and overwritten results are counted per channel.

## Interface
- `IMG_HDISP`, 11'd1024, active width; boxes with `right >= IMG_HDISP` are invalid
- `IMG_VDISP`, 11'd768, active height; boxes with `down >= IMG_VDISP` are invalid
- `HOLD_FRAMES`, 4'd4, frames a last-good box is re-issued after loss (only with `BOX_HOLD_EN`)
- `clk`  in  1  single clock; all inputs synchronous to it
- `rst`  in  1  asynchronous, active-high reset
- `ch0_vsync`, `ch1_vsync`  in  1  per-channel frame sync; rising edge marks the end of the previous frame
- `chN_up`, `chN_down`, `chN_left`, `chN_right`  in  11  detector box, stable across the vsync edge
- `chN_flag`  in  1  detector found a target in the last frame
- `out_valid`  out  1  result presented
- `out_ready`  in  1  consumer accepts
- `out_ch`  out  1  source channel
- `out_up`, `out_down`, `out_left`, `out_right`  out  11  box
- `out_flag`  out  1  box valid
- `out_held`  out  1  box is a held copy; constant 0 without `BOX_HOLD_EN`
- `drop_cnt0`, `drop_cnt1`  out  8  saturating count of overwritten pending results

## Operation
- Edge detect: `vs_d[N]` is a registered copy of `chN_vsync`; `cap[N] = chN_vsync & ~vs_d[N]`.
- Capture: on `cap[N]`, slot N loads the box and `flag`, and `pend[N]` is set.
- Validation at capture: if `flag=1` and any of the following holds, the stored flag is 0 and the stored box is all-zero:
  - `left > right`
  - `up > down`
  - `right >= IMG_HDISP`
  - `down >= IMG_VDISP`
- Flag=0 slots always store box 0.
- Overwrite: `cap[N]` with `pend[N]` already 1 and slot N not granted this cycle increments `drop_cntN`. The count saturates at 255.
- Output stage, two states:
  - IDLE (`out_valid=0`)
  - PRESENT (`out_valid=1`)
- Load condition: `load = (~out_valid | out_ready) & (pend[0] | pend[1])`.
- Grant:
  - One pending channel: that channel.
  - Both pending: the channel other than `last`, where `last` is the channel most recently granted.
- On load, the output registers take the granted slot's pre-update content. `pend[g]` clears, `last <= g`, state goes to PRESENT.
- `out_ready & out_valid` with nothing pending: state goes to IDLE. Output data registers keep their values.
- PRESENT without `out_ready`: all `out_*` are held stable.
- Simultaneous `cap[g]` and grant of g: the old content is issued, the slot takes the new capture, `pend[g]` stays 1, and no drop is counted.
- Captures on both channels in the same cycle are independent.

## Timing
- Reset values:
  - `out_valid=0`, `out_ch=0`
  - all `out_*` box/flag/held = 0
  - `pend=0`, `vs_d=0`
  - `last=1`, so ch0 wins the first tie
  - `drop_cnt*=0`, hold counters 0
- Latency: `chN_vsync` first sampled high at edge E, so the slot loads at E. `out_valid` rises at E+1 if the output is free.
- Throughput: one result per cycle with `out_ready` held high; back-to-back loads require no bubble.
- Reset mid-handshake: `out_valid` drops immediately (async). Pending results are discarded.
- A vsync already high when `rst` deasserts does not capture: `vs_d` resets to 0, but the first post-reset sample is gated for one cycle.

## Configuration
- `BOX_HOLD_EN` defined:
  - Per channel, keep `good_boxN` and a 4-bit `missN`.
  - Capture with stored flag=1 updates `good_boxN`, sets `missN=0`, and issues with `out_held=0`.
  - Capture with stored flag=0 and `missN < HOLD_FRAMES`: `missN++` and issue `good_boxN` with `out_flag=1`, `out_held=1`. This applies only if a good box has been seen since reset.
  - Otherwise the flag=0 result is issued as-is.
- `BOX_HOLD_EN` undefined: the hold logic is absent, `out_held` is tied 0, and results pass through validation only.

## Test plan
- Reset release, ch0 vsync edge with box (10,50,20,80) and flag=1: `out_valid` rises 1 cycle after capture, `out_ch=0`, box matches; held until `out_ready`.
- Both vsync edges in the same cycle, `out_ready=1`: ch0 issued first, ch1 next cycle. A repeat both-edge event then issues ch1 first.
- `out_ready=0`, three ch1 edges: `drop_cnt1=2`. After ready, only the third box is issued. 260 overwrites give `drop_cnt1=255`.
- ch0 box with left=30 > right=20 and flag=1: issued with `out_flag=0` and a zero box. `right=1024` gives the same result.
- With `BOX_HOLD_EN`, HOLD_FRAMES=4: one good box, then 6 flag=0 frames. Frames 1–4 issue the good box with `out_held=1`; frames 5–6 issue flag=0, `out_held=0`.
- `rst` pulse while `out_valid=1` and ch1 pending: all outputs 0 and no further issue until a new vsync edge.
